// File: rtl/sp_capture_ctrl.sv
// SP FIFO capture controller: nWire edge detect, block capture, overrun.
// Optional decimation built when SP_DECIM_EN is defined.
module sp_capture_ctrl #(
  parameter int CHANNELS   = 2,
  parameter int BLOCK_SIZE = 4096,
  parameter int DECIM_W    = 4,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int NW = $clog2(BLOCK_SIZE + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] spd_rdy,
  output logic [CHANNELS-1:0] spd_ack,
  input  logic [CW-1:0]       chan_sel,
  input  logic                mode,
  input  logic                arm,
  input  logic [DECIM_W-1:0]  decim,
  input  logic                fifo_wrempty,
  input  logic                fifo_wrfull,
  output logic                write,
  output logic                have_sp_data,
  output logic                capturing,
  output logic                overrun
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_EMPTY,
    CAPTURE
  } state_t;

  state_t state, state_nx;

  logic [CHANNELS-1:0] edg;
  logic [CW-1:0]       ch;
  logic [NW-1:0]       cnt;
  logic                sel_edge;
  logic                done;
  logic                full_hit;
  logic                dhit;
  logic                take;
  logic                start;
  logic                step;

`ifdef SP_DECIM_EN
  logic [DECIM_W-1:0] dfac;
  logic [DECIM_W-1:0] dcnt;
  assign dhit = (dcnt == '0);
`else
  logic unused_decim;
  assign unused_decim = ^decim;
  assign dhit = 1'b1;
`endif

  always_comb begin
    sel_edge = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch == CW'(i)) sel_edge = edg[i];
    end
  end

  assign capturing    = (state == CAPTURE);
  assign have_sp_data = !capturing;
  assign done         = (cnt == NW'(BLOCK_SIZE));
  assign full_hit     = capturing && fifo_wrfull && !done;
  assign step         = capturing && sel_edge && !done
                        && !full_hit;
  assign take         = step && dhit;
  assign start        = (state == WAIT_EMPTY) && fifo_wrempty;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (!mode || arm) state_nx = WAIT_EMPTY;
      end
      WAIT_EMPTY: begin
        if (fifo_wrempty) state_nx = CAPTURE;
      end
      CAPTURE: begin
        if (full_hit || done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      spd_ack <= '0;
      edg     <= '0;
      write   <= 1'b0;
      ch      <= '0;
      cnt     <= '0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nx;
      spd_ack <= spd_rdy;
      edg     <= spd_rdy & ~spd_ack;
      write   <= take;
      if (start) begin
        ch  <= chan_sel;
        cnt <= '0;
      end else if (take) begin
        cnt <= cnt + NW'(1);
      end
      // a full seen this cycle outranks a clearing arm
      if (full_hit)  overrun <= 1'b1;
      else if (arm)  overrun <= 1'b0;
    end
  end

`ifdef SP_DECIM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      dfac <= '0;
      dcnt <= '0;
    end else if (start) begin
      dfac <= decim;
      dcnt <= '0;
    end else if (step) begin
      dcnt <= (dcnt >= dfac) ? '0 : dcnt + DECIM_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_sp_capture_ctrl.sv
// Scoreboard bench for sp_capture_ctrl: expected write cycles are
// queued at stimulus time and checked by an independent monitor.
module tb_sp_capture_ctrl;

  localparam int CH = 2;
  localparam int BS = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] spd_rdy;
  logic [CH-1:0] spd_ack;
  logic [0:0]    chan_sel;
  logic          mode;
  logic          arm;
  logic [3:0]    decim;
  logic          fifo_wrempty;
  logic          fifo_wrfull;
  logic          write;
  logic          have_sp_data;
  logic          capturing;
  logic          overrun;

  int n_chk  = 0;
  int n_fail = 0;
  int n_wr   = 0;
  int cyc    = 0;
  int fcnt   = 0;
  int full_lvl = 1000;
  bit drain_req = 0;
  int exq[$];

  sp_capture_ctrl #(
    .CHANNELS(CH), .BLOCK_SIZE(BS), .DECIM_W(4)
  ) dut (
    .clk(clk), .reset(reset),
    .spd_rdy(spd_rdy), .spd_ack(spd_ack),
    .chan_sel(chan_sel), .mode(mode), .arm(arm),
    .decim(decim),
    .fifo_wrempty(fifo_wrempty), .fifo_wrfull(fifo_wrfull),
    .write(write), .have_sp_data(have_sp_data),
    .capturing(capturing), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO occupancy model, drained on request by the stimulus
  always @(posedge clk) begin
    if (drain_req) fcnt <= 0;
    else if (write) fcnt <= fcnt + 1;
  end
  assign fifo_wrempty = (fcnt == 0);
  assign fifo_wrfull  = (fcnt >= full_lvl);

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (write) begin
      n_wr++;
      if (exq.size() == 0) begin
        chk("unexpected_write", cyc, -1);
      end else begin
        chk("write_cycle", cyc, exq.pop_front());
      end
    end
  end

  task automatic pulse(input int c, input bit exp);
    @(negedge clk);
    spd_rdy[c] = 1'b1;
    if (exp) exq.push_back(cyc + 2);
    @(negedge clk);
    chk("ack_rise", int'(spd_ack[c]), 1);
    @(negedge clk);
    spd_rdy[c] = 1'b0;
    @(negedge clk);
    chk("ack_fall", int'(spd_ack[c]), 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    @(negedge clk);
    drain_req = 1'b1;
    @(negedge clk);
    drain_req = 1'b0;
  endtask

  task automatic do_arm();
    @(negedge clk);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_ack"}, int'(spd_ack), 0);
    chk({nm, "_write"}, int'(write), 0);
    chk({nm, "_capturing"}, int'(capturing), 0);
    chk({nm, "_have"}, int'(have_sp_data), 1);
    chk({nm, "_overrun"}, int'(overrun), 0);
  endtask

  initial begin
    reset    = 1'b1;
    spd_rdy  = '0;
    chan_sel = 1'b1;
    mode     = 1'b0;
    arm      = 1'b0;
    decim    = 4'd0;
    idle(3);
    chk_reset_vals("rst");

    // continuous block on ch1: 20 edges, 16 written
    reset = 1'b0;
    idle(3);
    chk("cap_start", int'(capturing), 1);
    chk("have_low", int'(have_sp_data), 0);
    for (int i = 0; i < 20; i++) pulse(1, i < BS);
    idle(2);
    chk("blk1_capturing", int'(capturing), 0);
    chk("blk1_have", int'(have_sp_data), 1);
    chk("blk1_writes", n_wr, BS);

    // unselected channel: acked, never written
    drain();
    idle(2);
    chk("blk2_cap", int'(capturing), 1);
    for (int i = 0; i < 8; i++) pulse(0, 1'b0);
    chk("ch0_nowrite", n_wr, BS);

    // reset after 5 writes aborts the block
    for (int i = 0; i < 5; i++) pulse(1, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("abort");
    reset = 1'b0;
    drain();
    idle(2);
    for (int i = 0; i < BS + 1; i++) pulse(1, i < BS);
    idle(2);
    chk("restart_writes", n_wr, 2 * BS + 5);
    chk("restart_idle", int'(capturing), 0);

    // single-shot: no capture until armed
    mode = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drain();
    for (int i = 0; i < 50; i++) pulse(1, 1'b0);
    chk("ss_noarm_cap", int'(capturing), 0);
    do_arm();
    idle(2);
    chk("ss_armed_cap", int'(capturing), 1);
    for (int i = 0; i < 20; i++) pulse(1, i < BS);
    drain();
    idle(3);
    chk("ss_stay_idle", int'(capturing), 0);
    for (int i = 0; i < 4; i++) pulse(1, 1'b0);
    chk("ss_writes", n_wr, 3 * BS + 5);

    // decimation by 4
    decim = 4'd3;
    drain();
    do_arm();
    idle(2);
    for (int i = 0; i < 64; i++) begin
`ifdef SP_DECIM_EN
      pulse(1, (i % 4) == 0);
`else
      pulse(1, i < BS);
`endif
    end
    idle(2);
    chk("decim_writes", n_wr, 4 * BS + 5);
    chk("decim_idle", int'(capturing), 0);

    // early full after 10 writes
    decim    = 4'd0;
    full_lvl = 10;
    drain();
    do_arm();
    idle(2);
    for (int i = 0; i < BS; i++) pulse(1, i < 10);
    chk("ovr_set", int'(overrun), 1);
    chk("ovr_idle", int'(capturing), 0);
    chk("ovr_writes", n_wr, 4 * BS + 15);
    do_arm();
    chk("ovr_clear", int'(overrun), 0);

    idle(4);
    chk("queue_empty", exq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
